sixteen_bit_serial_subtractor: RTL and testbench

Bit-serial 16-bit subtractor with borrow-in and borrow-out. It computes `diff = a - b - bin` one bit per clock, LSB first, under a start/busy/done handshake. It is the inverse-operation companion to the combinational `sixteen_bit_adder` and shares its operand widths and carry/borrow conventions. It targets area-constrained datapaths where a 17-cycle result latency is acceptable.

---
 rtl/sixteen_bit_serial_subtractor.sv | 126 ++++++++++++
 tb/tb_sixteen_bit_serial_subtractor.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sixteen_bit_serial_subtractor.sv
// Bit-serial 16-bit subtractor: diff = a - b - bin, LSB first, start/busy/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module sixteen_bit_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       cnt_reg;
  logic [WIDTH-1:0] a_sr_reg, b_sr_reg, res_sr_reg;
  logic [WIDTH-1:0] a_shr, b_shr, res_next;
  logic             brw_reg, brw_next, d_bit;
  logic [WIDTH-1:0] diff_reg;
  logic             bout_reg;
  logic             last_bit;

  // One full-subtractor slice; operand LSBs are the current bit.
  assign d_bit    = a_sr_reg[0] ^ b_sr_reg[0] ^ brw_reg;
  assign brw_next = (~a_sr_reg[0] & b_sr_reg[0]) | (~(a_sr_reg[0] ^ b_sr_reg[0]) & brw_reg);
  assign last_bit = (cnt_reg == 4'(WIDTH - 1));

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == WIDTH - 1) begin : g_msb
        assign a_shr[gi]    = 1'b0;
        assign b_shr[gi]    = 1'b0;
        assign res_next[gi] = d_bit;
      end else begin : g_body
        assign a_shr[gi]    = a_sr_reg[gi+1];
        assign b_shr[gi]    = b_sr_reg[gi+1];
        assign res_next[gi] = res_sr_reg[gi+1];
      end
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      a_sr_reg   <= '0;
      b_sr_reg   <= '0;
      res_sr_reg <= '0;
      brw_reg    <= 1'b0;
      diff_reg   <= '0;
      bout_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_sr_reg <= a;
            b_sr_reg <= b;
            brw_reg  <= bin;
            cnt_reg  <= '0;
          end
        end
        RUN: begin
          a_sr_reg   <= a_shr;
          b_sr_reg   <= b_shr;
          res_sr_reg <= res_next;
          brw_reg    <= brw_next;
          cnt_reg    <= cnt_reg + 4'd1;
          if (last_bit) begin
            diff_reg <= res_next;
            bout_reg <= brw_next;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_reg;

  // On the final bit the shift-register LSBs hold the original operand sign bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (state_reg == RUN && last_bit) begin
      ovf_reg <= (a_sr_reg[0] ^ b_sr_reg[0]) & (d_bit ^ a_sr_reg[0]);
    end
  end

  assign ovf = ovf_reg;
`endif

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign diff = diff_reg;
  assign bout = bout_reg;

endmodule

// File: tb/tb_sixteen_bit_serial_subtractor.sv
// Self-checking bench for sixteen_bit_serial_subtractor: cycle-level arithmetic model plus
// directed vectors with literal expectations. Honors SERIAL_SUB_OVF_EN like the design.
module tb_sixteen_bit_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst, start, bin;
  logic [15:0] a, b;
  logic        busy, done, bout;
  logic [15:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic        ovf;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en    = 1'b0;
  bit hold_mode = 1'b0;
  int last_done = -1;
  int n_done_hold = 0;

  sixteen_bit_serial_subtractor #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Reference arithmetic: {ovf, bout, diff}
  function automatic logic [17:0] sub_model(input logic [15:0] x, input logic [15:0] y,
                                            input logic bi);
    logic [16:0] t;
    logic        o;
    t = {1'b0, x} - {1'b0, y} - {16'd0, bi};
    o = (x[15] ^ y[15]) & (t[15] ^ x[15]);
    return {o, t[16], t[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  // Model: m_age counts cycles since acceptance (0 = idle, 17 = done cycle).
  int          m_age = 0;
  logic [15:0] m_a, m_b, m_diff;
  logic        m_bin, m_bout, m_ovf;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_age <= 0; m_diff <= '0; m_bout <= 1'b0; m_ovf <= 1'b0;
    end else if (m_age == 0) begin
      if (start) begin
        m_age <= 1; m_a <= a; m_b <= b; m_bin <= bin;
      end
    end else if (m_age == 16) begin
      m_age <= 17;
      {m_ovf, m_bout, m_diff} <= sub_model(m_a, m_b, m_bin);
    end else if (m_age == 17) begin
      m_age <= 0;
    end else begin
      m_age <= m_age + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_age >= 1 && m_age <= 16));
      check("done", 32'(done), 32'(m_age == 17));
      check("diff", 32'(diff), 32'(m_diff));
      check("bout", 32'(bout), 32'(m_bout));
`ifdef SERIAL_SUB_OVF_EN
      check("ovf", 32'(ovf), 32'(m_ovf));
`endif
      if (busy && done) check("busy_done_overlap", 32'd1, 32'd0);
      if (done && hold_mode) begin
        n_done_hold++;
        if (last_done >= 0) check("done_spacing", 32'(cyc - last_done), 32'd18);
        last_done = cyc;
      end
    end
  end

  task automatic run_op(input logic [15:0] xa, input logic [15:0] xb, input logic xbin,
                        input logic [15:0] e_diff, input logic e_bout, input logic e_ovf);
    bit seen;
    @(negedge clk);
    a = xa; b = xb; bin = xbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("lit_diff", 32'(diff), 32'(e_diff));
      check("lit_bout", 32'(bout), 32'(e_bout));
`ifdef SERIAL_SUB_OVF_EN
      check("lit_ovf", 32'(ovf), 32'(e_ovf));
`else
      if (e_ovf) ;
`endif
    end
    $display("op a=%h b=%h bin=%0d -> diff=%h bout=%0d", xa, xb, xbin, diff, bout);
  endtask

  initial begin
    int nd;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    rst = 1'b0;

    run_op(16'h0003, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
    run_op(16'h0004, 16'h0003, 1'b1, 16'h0000, 1'b0, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    run_op(16'h0001, 16'hFFFF, 1'b1, 16'h0001, 1'b1, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    run_op(16'h3FFF, 16'h7FFF, 1'b0, 16'hC000, 1'b1, 1'b0);

    // Outputs must hold through a later RUN.
    @(negedge clk);
    a = 16'h0100; b = 16'h0001; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("hold_diff", 32'(diff), 32'h0000C000);
    check("hold_bout", 32'(bout), 32'd1);
    repeat (15) @(negedge clk);

    // Back-to-back with start held high and operands churning every cycle.
    hold_mode = 1'b1; last_done = -1; n_done_hold = 0;
    start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      a = 16'(i * 16'h1357 + 3);
      b = 16'(i * 16'h0F0F);
      bin = i[0];
      @(negedge clk);
    end
    start = 1'b0;
    repeat (20) @(negedge clk);
    hold_mode = 1'b0;
    check("hold_done_count", 32'(n_done_hold >= 3), 32'd1);
    $display("held start: %0d done pulses", n_done_hold);

    // Abort with reset around bit 8.
    @(negedge clk);
    a = 16'h1234; b = 16'h0034; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_bout", 32'(bout), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    nd = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("abort_no_done", 32'(nd), 32'd0);
    $display("reset abort: done pulses after abort=%0d", nd);
    run_op(16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
